// File: rtl/fixed_arith_unit_pkg.sv
// Shared constants and types for the CORDIC fixed-point support unit.
package fixed_arith_unit_pkg;

   localparam int unsigned FIXED_WIDTH      = 22;
   localparam int unsigned FRACTIONAL_WIDTH = 21;
   localparam int unsigned FLOAT_WIDTH      = 32;
   localparam int unsigned EXP_WIDTH        = 8;
   localparam int unsigned MANT_WIDTH       = 23;
   localparam int unsigned FLOAT_BIAS       = 127;

   // 1.0 as an IEEE-754 single
   localparam logic [FLOAT_WIDTH-1:0] FLOAT_ONE = 32'h3F80_0000;

   typedef logic signed [FIXED_WIDTH-1:0] fixed_t;

   typedef struct packed {
      logic                  sign;
      logic [EXP_WIDTH-1:0]  exp;
      logic [MANT_WIDTH-1:0] mant;
   } float_t;

endpackage

// File: rtl/fixed_arith_unit_fixed_to_float_pipe.sv
// Four-stage exact fixed-point to single-precision converter with enable-qualified valid.
module fixed_to_float_pipe
   import fixed_arith_unit_pkg::*;
#(
   parameter int unsigned FIXED_WIDTH      = 22,
   parameter int unsigned FRACTIONAL_WIDTH = 21,
   parameter int unsigned FLOAT_WIDTH      = 32,
   parameter int unsigned CVT_LATENCY      = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic [FIXED_WIDTH-1:0] data,
   output logic [FLOAT_WIDTH-1:0] result,
   output logic                   valid
);

   // One extra bit so that the most negative value has a representable magnitude.
   localparam int unsigned MAG_WIDTH  = FIXED_WIDTH + 1;
   localparam int unsigned POS_WIDTH  = $clog2(MAG_WIDTH);
   localparam int unsigned EXP_OFFSET = FLOAT_BIAS - FRACTIONAL_WIDTH;

   logic [FIXED_WIDTH-1:0] s1_data;
   logic                   s2_sign;
   logic [MAG_WIDTH-1:0]   s2_mag;
   logic                   s3_sign;
   logic [MAG_WIDTH-1:0]   s3_mag;
   logic [POS_WIDTH-1:0]   s3_pos;
   float_t                 s4_float;
   logic [CVT_LATENCY-1:0] valid_sr;

   logic [MAG_WIDTH-1:0]   ext_c;
   logic [MAG_WIDTH-1:0]   abs_c;
   logic [POS_WIDTH-1:0]   lead_pos_c;
   logic [MAG_WIDTH-1:0]   norm_c;
   float_t                 pack_c;

   // Stage 2 logic: sign-extend and take the absolute value.
   always_comb begin
      ext_c = {s1_data[FIXED_WIDTH-1], s1_data};
      abs_c = ext_c;
      if (s1_data[FIXED_WIDTH-1]) begin
         abs_c = MAG_WIDTH'(~ext_c + 1'b1);
      end
   end

   // Stage 3 logic: position of the most significant set bit (0 when magnitude is zero).
   always_comb begin
      lead_pos_c = '0;
      for (int i = 0; i < int'(MAG_WIDTH); i++) begin
         if (s2_mag[i]) begin
            lead_pos_c = POS_WIDTH'(i);
         end
      end
   end

   // Stage 4 logic: shift the hidden one out the top and pack sign/exponent/mantissa.
   always_comb begin
      norm_c      = s3_mag << (MAG_WIDTH - 32'(s3_pos));
      pack_c.sign = s3_sign;
      pack_c.exp  = EXP_WIDTH'(EXP_OFFSET + 32'(s3_pos));
      pack_c.mant = MANT_WIDTH'(norm_c) << (MANT_WIDTH - MAG_WIDTH);
      if (s3_mag == '0) begin
         pack_c = '0;
      end
   end

   // Pipeline registers and valid token shift; reset flushes, enable low freezes all stages.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_data  <= '0;
         s2_sign  <= 1'b0;
         s2_mag   <= '0;
         s3_sign  <= 1'b0;
         s3_mag   <= '0;
         s3_pos   <= '0;
         s4_float <= '0;
         valid_sr <= '0;
      end else if (en) begin
         s1_data  <= data;
         s2_sign  <= s1_data[FIXED_WIDTH-1];
         s2_mag   <= abs_c;
         s3_sign  <= s2_sign;
         s3_mag   <= s2_mag;
         s3_pos   <= lead_pos_c;
         s4_float <= pack_c;
         valid_sr <= {valid_sr[CVT_LATENCY-2:0], 1'b1};
      end
   end

   assign result = FLOAT_WIDTH'(s4_float);
   assign valid  = valid_sr[CVT_LATENCY-1];

endmodule

// File: rtl/fixed_arith_unit.sv
// CORDIC support unit: pipelined fixed-to-float converter plus combinational add/sub and compare.
module fixed_arith_unit
   import fixed_arith_unit_pkg::*;
#(
   parameter int unsigned INTEGER_WIDTH    = 1,
   parameter int unsigned FRACTIONAL_WIDTH = fixed_arith_unit_pkg::FRACTIONAL_WIDTH,
   parameter int unsigned FIXED_WIDTH      = INTEGER_WIDTH + FRACTIONAL_WIDTH,
   parameter int unsigned FLOAT_WIDTH      = fixed_arith_unit_pkg::FLOAT_WIDTH,
   parameter int unsigned CVT_LATENCY      = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cvt_en,
   input  logic [FIXED_WIDTH-1:0] cvt_data,
   output logic [FLOAT_WIDTH-1:0] cvt_result,
   output logic                   cvt_valid,
   input  logic [FIXED_WIDTH-1:0] as_a,
   input  logic [FIXED_WIDTH-1:0] as_b,
   input  logic                   as_add,
   output logic [FIXED_WIDTH-1:0] as_result,
   input  logic [FIXED_WIDTH-1:0] cmp_a,
   input  logic [FIXED_WIDTH-1:0] cmp_b,
   output logic                   cmp_eq,
   output logic                   cmp_gt
);

   fixed_to_float_pipe #(
      .FIXED_WIDTH      (FIXED_WIDTH),
      .FRACTIONAL_WIDTH (FRACTIONAL_WIDTH),
      .FLOAT_WIDTH      (FLOAT_WIDTH),
      .CVT_LATENCY      (CVT_LATENCY)
   ) u_cvt (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (cvt_en),
      .data   (cvt_data),
      .result (cvt_result),
      .valid  (cvt_valid)
   );

   // Wrapping add/sub used by each micro-rotation.
   always_comb begin
      as_result = as_add ? (as_a + as_b) : (as_a - as_b);
   end

   // Signed two's-complement magnitude compare.
   always_comb begin
      cmp_eq = (cmp_a == cmp_b);
      cmp_gt = ($signed(cmp_a) > $signed(cmp_b));
   end

endmodule

// File: tb/tb_fixed_arith_unit.sv
// Scoreboard bench for fixed_arith_unit: converter stream with stalls/reset, plus add/sub and compare.
module tb_fixed_arith_unit;
   import fixed_arith_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cvt_en;
   logic [21:0] cvt_data;
   logic [31:0] cvt_result;
   logic        cvt_valid;
   logic [21:0] as_a, as_b, as_result;
   logic        as_add;
   logic [21:0] cmp_a, cmp_b;
   logic        cmp_eq, cmp_gt;

   logic [31:0] exp_in;
   logic [31:0] exp_q[$];
   logic [31:0] exp_res;
   int          tokens;
   int          checks = 0;
   int          errors = 0;

   fixed_arith_unit dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cvt_en     (cvt_en),
      .cvt_data   (cvt_data),
      .cvt_result (cvt_result),
      .cvt_valid  (cvt_valid),
      .as_a       (as_a),
      .as_b       (as_b),
      .as_add     (as_add),
      .as_result  (as_result),
      .cmp_a      (cmp_a),
      .cmp_b      (cmp_b),
      .cmp_eq     (cmp_eq),
      .cmp_gt     (cmp_gt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", tag, got, want);
      end
   endtask

   // Reference conversion: highest set bit found top-down, hidden one masked off.
   function automatic logic [31:0] fx2fl(input logic [21:0] v);
      logic [22:0] m;
      logic [22:0] frac;
      int          msb;
      m = {v[21], v};
      if (v[21]) m = ~m + 23'd1;
      if (m == 23'd0) return 32'd0;
      msb = 0;
      for (int i = 22; i >= 0; i--) begin
         if (m[i]) begin
            msb = i;
            break;
         end
      end
      frac = m & ~(23'd1 << msb);
      frac = frac << (23 - msb);
      return {v[21], 8'(106 + msb), frac};
   endfunction

   // Scoreboard: push on enabled edges, pop once four enabled edges have elapsed since reset.
   always @(posedge clk) begin
      logic       rst_s;
      logic       en_s;
      logic [31:0] e_s;
      rst_s = rst_n;
      en_s  = cvt_en;
      e_s   = exp_in;
      if (!rst_s) begin
         exp_q.delete();
         tokens  = 0;
         exp_res = 32'd0;
      end else if (en_s) begin
         exp_q.push_back(e_s);
         tokens++;
         if (tokens >= 4) begin
            if (exp_q.size() == 0) begin
               check("sb_underflow", 32'd1, 32'd0);
            end else begin
               exp_res = exp_q.pop_front();
            end
         end
      end
      #1;
      if (!rst_s) begin
         check("rst_result", cvt_result, 32'd0);
         check("rst_valid", 32'(cvt_valid), 32'd0);
      end else begin
         check(en_s ? "cvt_result" : "hold_result", cvt_result, exp_res);
         check(en_s ? "cvt_valid" : "hold_valid", 32'(cvt_valid), 32'(tokens >= 4));
      end
   end

   task automatic drive(input logic en, input logic [21:0] d, input logic [31:0] e);
      @(negedge clk);
      cvt_en   = en;
      cvt_data = d;
      exp_in   = e;
   endtask

   task automatic drive_as(input logic [21:0] a, input logic [21:0] b, input logic add,
                           input logic [21:0] want, input string tag);
      as_a = a; as_b = b; as_add = add;
      #1;
      check(tag, 32'(as_result), 32'(want));
   endtask

   task automatic drive_cmp(input logic [21:0] a, input logic [21:0] b,
                            input logic eq, input logic gt, input string tag);
      cmp_a = a; cmp_b = b;
      #1;
      check({tag, "_eq"}, 32'(cmp_eq), 32'(eq));
      check({tag, "_gt"}, 32'(cmp_gt), 32'(gt));
   endtask

   initial begin
      logic [21:0] d;
      logic [21:0] a, b;
      logic [21:0] sum;
      int          sa, sb;
      logic        add;
      logic [31:0] neg_one;

      rst_n = 1'b0; cvt_en = 1'b1; cvt_data = 22'h0; exp_in = 32'h0;
      as_a = '0; as_b = '0; as_add = 1'b1; cmp_a = '0; cmp_b = '0;
      neg_one = FLOAT_ONE;
      neg_one[31] = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // CORDIC gain, then idle zeros to watch the exact latency
      drive(1'b1, 22'h136E9D, 32'h3F1B74E8);
      repeat (3) drive(1'b1, 22'h000000, 32'h0);

      // back-to-back stream
      drive(1'b1, 22'h100000, 32'h3F000000);
      drive(1'b1, 22'h200000, neg_one);
      drive(1'b1, 22'h3FFFFF, 32'hB5000000);
      drive(1'b1, 22'h000000, 32'h00000000);

      // stall mid-stream
      drive(1'b1, 22'h0C90FD, fx2fl(22'h0C90FD));
      drive(1'b1, 22'h1FFFFF, fx2fl(22'h1FFFFF));
      repeat (3) drive(1'b0, 22'h2AAAAA, fx2fl(22'h2AAAAA));
      drive(1'b1, 22'h000001, fx2fl(22'h000001));
      repeat (3) drive(1'b1, 22'h0, 32'h0);

      // random data with random enable gaps
      for (int i = 0; i < 40; i++) begin
         d = 22'($urandom);
         drive(($urandom_range(0, 3) != 0), d, fx2fl(d));
      end

      // reset pulse mid-stream with enable held high
      drive(1'b1, 22'h155555, fx2fl(22'h155555));
      drive(1'b1, 22'h0AAAAA, fx2fl(22'h0AAAAA));
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      cvt_data = 22'h3C0000; exp_in = fx2fl(22'h3C0000);
      for (int i = 0; i < 8; i++) begin
         d = 22'($urandom);
         drive(1'b1, d, fx2fl(d));
      end
      repeat (5) drive(1'b1, 22'h0, 32'h0);
      drive(1'b0, 22'h0, 32'h0);

      // add/sub directed cases
      drive_as(22'h136E9D, 22'h000000, 1'b1, 22'h136E9D, "as_add_zero");
      drive_as(22'h100000, 22'h100000, 1'b1, 22'h200000, "as_add_wrap");
      drive_as(22'h000000, 22'h000001, 1'b0, 22'h3FFFFF, "as_sub_wrap");
      for (int i = 0; i < 16; i++) begin
         a = 22'($urandom); b = 22'($urandom); add = 1'($urandom);
         sum = add ? 22'(32'(a) + 32'(b)) : 22'(32'(a) + 32'h400000 - 32'(b));
         drive_as(a, b, add, sum, "as_rand");
      end

      // comparator directed cases
      drive_cmp(22'h3FFFFF, 22'h000001, 1'b0, 1'b0, "cmp_neg_pos");
      drive_cmp(22'h0C90FD, 22'h0C90FD, 1'b1, 1'b0, "cmp_equal");
      drive_cmp(22'h100000, 22'h200000, 1'b0, 1'b1, "cmp_pos_min");
      drive_cmp(22'h1FFFFF, 22'h200000, 1'b0, 1'b1, "cmp_max_min");
      for (int i = 0; i < 16; i++) begin
         a = 22'($urandom); b = (i % 4 == 0) ? a : 22'($urandom);
         sa = int'(a) - (a[21] ? 32'h400000 : 0);
         sb = int'(b) - (b[21] ? 32'h400000 : 0);
         drive_cmp(a, b, (sa == sb), (sa > sb), "cmp_rand");
      end

      if (exp_q.size() != 3) check("sb_depth", 32'(exp_q.size()), 32'd3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
